// File: rtl/ip_stack_pkg.sv
// Shared IP stack constants: protocol codes, TX arbiter state encoding and
// default gap / grant-timeout values.
package ip_stack_pkg;

    localparam logic [7:0]  PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PROTO_ICMP = 8'd1;

    localparam logic [15:0] GAP_CYCLES_DEF    = 16'd12;
    localparam logic [15:0] GRANT_TIMEOUT_DEF = 16'd255;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_GRANT = 2'd1;
    localparam logic [1:0]  ST_XFER  = 2'd2;
    localparam logic [1:0]  ST_GAP   = 2'd3;

endpackage

// File: rtl/ip_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: bit 0 = UDP, bit 1 = ICMP. On contention the
// source other than the most recently served one wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       served,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = served ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Arbitrates the UDP and ICMP sources onto the shared IP TX path, forwarding
// the owner's byte stream with one cycle of latency and a fixed inter-packet gap.
module ip_tx_arbiter
    import ip_stack_pkg::*;
#(
    parameter logic [7:0]  P_TYPE_UDP      = PROTO_UDP,
    parameter logic [7:0]  P_TYPE_ICMP     = PROTO_ICMP,
    parameter logic [15:0] P_GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter logic [15:0] P_GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_udp_req,
    output logic        o_udp_grant,
    input  logic [7:0]  i_udp_data,
    input  logic [15:0] i_udp_len,
    input  logic        i_udp_last,
    input  logic        i_udp_valid,
    input  logic        i_icmp_req,
    output logic        o_icmp_grant,
    input  logic [7:0]  i_icmp_data,
    input  logic [15:0] i_icmp_len,
    input  logic        i_icmp_last,
    input  logic        i_icmp_valid,
    output logic [7:0]  o_send_data,
    output logic [7:0]  o_send_type,
    output logic [15:0] o_send_len,
    output logic        o_send_last,
    output logic        o_send_valid,
    output logic        o_busy,
    output logic        o_timeout
);

    logic [1:0]  state;
    logic        owner;      // 0 = UDP, 1 = ICMP
    logic        served;     // most recently served source
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;
    logic [1:0]  pick;

    logic        src_req;
    logic        src_valid;
    logic        src_last;
    logic [7:0]  src_data;
    logic [15:0] src_len;
    logic        wait_hit;
    logic        gap_done;

    rr_arb2 u_rr_arb2 (
        .req    ({i_icmp_req, i_udp_req}),
        .served (served),
        .pick   (pick)
    );

    always_comb begin
        src_req   = owner ? i_icmp_req   : i_udp_req;
        src_valid = owner ? i_icmp_valid : i_udp_valid;
        src_last  = owner ? i_icmp_last  : i_udp_last;
        src_data  = owner ? i_icmp_data  : i_udp_data;
        src_len   = owner ? i_icmp_len   : i_udp_len;
        // 17-bit compares keep a zero parameter from wrapping the limit
        wait_hit  = ({1'b0, wait_cnt} + 17'd1) >= {1'b0, P_GRANT_TIMEOUT};
        gap_done  = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, P_GAP_CYCLES};
        o_busy    = (state != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= ST_IDLE;
            owner        <= 1'b0;
            served       <= 1'b1;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
            o_udp_grant  <= 1'b0;
            o_icmp_grant <= 1'b0;
            o_send_data  <= '0;
            o_send_type  <= '0;
            o_send_len   <= '0;
            o_send_last  <= 1'b0;
            o_send_valid <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_send_data  <= '0;
            o_send_last  <= 1'b0;
            o_send_valid <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        state        <= ST_GRANT;
                        owner        <= pick[1];
                        o_udp_grant  <= pick[0];
                        o_icmp_grant <= pick[1];
                        o_send_type  <= pick[1] ? P_TYPE_ICMP : P_TYPE_UDP;
                        wait_cnt     <= '0;
                    end
                end
                ST_GRANT: begin
                    if (src_valid) begin
                        o_send_data  <= src_data;
                        o_send_valid <= 1'b1;
                        o_send_last  <= src_last;
                        o_send_len   <= src_len;
                        if (src_last) begin
                            state        <= ST_GAP;
                            gap_cnt      <= '0;
                            served       <= owner;
                            o_udp_grant  <= 1'b0;
                            o_icmp_grant <= 1'b0;
                        end else begin
                            state <= ST_XFER;
                        end
                    end else if (!src_req) begin
                        state        <= ST_IDLE;
                        o_udp_grant  <= 1'b0;
                        o_icmp_grant <= 1'b0;
                    end else if (wait_hit) begin
                        state        <= ST_GAP;
                        gap_cnt      <= '0;
                        served       <= owner;
                        o_timeout    <= 1'b1;
                        o_udp_grant  <= 1'b0;
                        o_icmp_grant <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_XFER: begin
                    o_send_data  <= src_data;
                    o_send_valid <= src_valid;
                    o_send_last  <= src_valid & src_last;
                    if (src_valid && src_last) begin
                        state        <= ST_GAP;
                        gap_cnt      <= '0;
                        served       <= owner;
                        o_udp_grant  <= 1'b0;
                        o_icmp_grant <= 1'b0;
                    end
                end
                default: begin
                    if (gap_done) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- P_TYPE_UDP, 8'd17, protocol code driven on o_send_type for UDP packets.
- P_TYPE_ICMP, 8'd1, protocol code driven on o_send_type for ICMP packets.
- P_GAP_CYCLES, 16'd12, idle cycles forced between packets.
- P_GRANT_TIMEOUT, 16'd255, cycles a granted source may wait before its first valid.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, sole clock.
- i_rst, in, 1, synchronous, active-low reset.
- i_udp_req, in, 1, UDP source requests the IP TX path.
- o_udp_grant, out, 1, UDP source owns the path.
- i_udp_data, in, 8, UDP payload byte.
- i_udp_len, in, 16, UDP packet length.
- i_udp_last, in, 1, last UDP byte.
- i_udp_valid, in, 1, UDP byte valid.
- i_icmp_req, in, 1, ICMP request.
- o_icmp_grant, out, 1, ICMP grant.
- i_icmp_data, in, 8, ICMP payload byte.
- i_icmp_len, in, 16, ICMP packet length.
- i_icmp_last, in, 1, last ICMP byte.
- i_icmp_valid, in, 1, ICMP byte valid.
- o_send_data, out, 8, byte to IP TX.
- o_send_type, out, 8, protocol code to IP TX.
- o_send_len, out, 16, packet length to IP TX.
- o_send_last, out, 1, last byte to IP TX.
- o_send_valid, out, 1, byte valid to IP TX.
- o_busy, out, 1, high in any state except IDLE.
- o_timeout, out, 1, one-cycle pulse when a grant is revoked.

Function
REQ-003 The FSM SHALL have the states IDLE, GRANT, XFER and GAP.
REQ-004 In IDLE, when any request is sampled high, the FSM SHALL enter GRANT and assert the selected grant in the following cycle (1-cycle grant latency).
REQ-005 When both requests are high, selection SHALL be round-robin: the source not most recently served wins; after reset UDP has priority.
REQ-006 At most one grant SHALL be high in any cycle.
REQ-007 In GRANT, valid from the granted source SHALL move the FSM to XFER; valid from the non-granted source SHALL always be ignored.
REQ-008 In GRANT, deassertion of the granted request before its first valid SHALL drop the grant and return the FSM to IDLE with no o_timeout pulse and no round-robin update.
REQ-009 In GRANT, a 16-bit counter SHALL count the wait; on reaching P_GRANT_TIMEOUT cycles the block SHALL:
- pulse o_timeout for one cycle;
- drop the grant;
- mark that source as served;
- enter GAP.
REQ-010 Forwarding SHALL be registered with 1-cycle latency: o_send_data/last/valid equal the granted source's data/last/valid of the previous cycle.
REQ-011 o_send_type SHALL equal the source's parameter code.
REQ-012 o_send_len SHALL be captured on the first valid byte and held constant until o_send_last.
REQ-013 Valid gaps during XFER SHALL be forwarded as gaps, with no timeout in XFER; requests deasserting mid-packet SHALL be ignored.
REQ-014 On a granted valid&last, including a 1-byte packet in GRANT, the grant SHALL drop in the next cycle, the source SHALL be marked served, and the FSM SHALL enter GAP.
REQ-015 GAP SHALL last exactly P_GAP_CYCLES cycles before the FSM enters IDLE; when P_GAP_CYCLES=0, GAP SHALL pass directly to IDLE in one cycle.
REQ-016 Requests arriving during GAP SHALL be held pending and arbitrated in IDLE.
REQ-017 Outside forwarded cycles, o_send_valid and o_send_last SHALL be 0.

Reset
REQ-018 When i_rst=0 at a clock edge, all outputs SHALL be 0 in the next cycle, the FSM SHALL return to IDLE, all counters SHALL clear, and round-robin SHALL favour UDP.
REQ-019 A reset mid-packet SHALL abort the packet with no synthesized o_send_last.

Structure
REQ-020 A shared package ip_stack_pkg SHALL hold:
- the protocol codes (UDP 17, ICMP 1);
- the FSM state encoding;
- the default gap and timeout constants.
REQ-021 The two-way round-robin selector SHALL be a sub-module rr_arb2 (inputs: req[1:0], served pointer; output: one-hot pick); all other logic SHALL be inline.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Only i_udp_req high, then a 4-byte packet (len=4) -> o_udp_grant after 1 cycle; o_send_type=17, o_send_len=4; 4 valid bytes with last on the 4th, each 1 cycle delayed; grant low next cycle; o_busy low after 12 GAP cycles.
- Both requests high from reset -> UDP is served first, then ICMP after the gap with o_send_type=1.
- Both requests high continuously for 4 packets -> grant order is UDP, ICMP, UDP, ICMP.
- ICMP granted but never asserts valid (P_GRANT_TIMEOUT=255) -> o_timeout pulse at cycle 255 after grant, grant dropped, no o_send_valid; next arbitration favours UDP.
- Reset asserted at the 3rd byte of a 10-byte UDP packet -> next cycle all outputs are 0 and no o_send_last; a fresh ICMP request afterwards gets a grant 1 cycle later.
- i_icmp_valid asserted during a UDP grant, plus a 1-byte UDP packet -> ICMP bytes never appear on o_send_*; a single byte is output with valid and last together.
